// File: rtl/rcb_arb_if.sv
// rcb_arb_if: lookup-read, host-write, RAM and status signals of one RCB arbiter.
interface rcb_arb_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int TAG_WIDTH  = 4
);
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [TAG_WIDTH-1:0]  rd_tag;
   logic                  rd_ready;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [TAG_WIDTH-1:0]  rd_tag_out;
   logic                  hpb_wr_req;
   logic [ADDR_WIDTH-1:0] hpb_wr_addr;
   logic [DATA_WIDTH-1:0] hpb_wr_data;
   logic [BE_WIDTH-1:0]   hpb_wr_byte_en;
   logic                  rcb_wr_done;
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [BE_WIDTH-1:0]   ram_be;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [15:0]           stat_rd_stall;

   modport slave (
      input  rd_req, rd_addr, rd_tag, hpb_wr_req, hpb_wr_addr, hpb_wr_data, hpb_wr_byte_en, ram_rdata,
      output rd_ready, rd_valid, rd_data, rd_tag_out, rcb_wr_done,
             ram_en, ram_we, ram_addr, ram_wdata, ram_be, stat_rd_stall
   );
   modport master (
      output rd_req, rd_addr, rd_tag, hpb_wr_req, hpb_wr_addr, hpb_wr_data, hpb_wr_byte_en, ram_rdata,
      input  rd_ready, rd_valid, rd_data, rd_tag_out, rcb_wr_done,
             ram_en, ram_we, ram_addr, ram_wdata, ram_be, stat_rd_stall
   );
endinterface

// File: rtl/rcb_arb.sv
// rcb_arb: shares one single-port RAM between lookup reads and host writes;
// reads win until a pending write has been blocked WR_STARVE_LIMIT cycles.
module rcb_arb #(
   parameter int ADDR_WIDTH      = 10,
   parameter int DATA_WIDTH      = 64,
   parameter int BE_WIDTH        = DATA_WIDTH / 8,
   parameter int TAG_WIDTH       = 4,
   parameter int RD_LATENCY      = 2,
   parameter int WR_STARVE_LIMIT = 8
) (
   input logic      clk,
   input logic      reset_n,
   rcb_arb_if.slave bus
);
   typedef enum logic [1:0] {W_IDLE, W_PEND, W_DONE, W_REARM} wr_state_t;

   wr_state_t             r_state, w_next;
   logic [7:0]            r_starve;
   logic [RD_LATENCY-1:0] r_vld;
   logic [TAG_WIDTH-1:0]  r_tag [RD_LATENCY];
   logic [15:0]           r_stall;
   logic                  w_lim, w_grant, w_rd_acc;

   assign w_lim    = r_state == W_PEND && r_starve == 8'(WR_STARVE_LIMIT);
   assign w_grant  = r_state == W_PEND && (!bus.rd_req || w_lim);
   assign w_rd_acc = bus.rd_req && !w_lim;

   always_comb begin
      w_next        = r_state;
      bus.ram_en    = w_rd_acc || w_grant;
      bus.ram_we    = w_grant;
      bus.ram_addr  = w_grant ? bus.hpb_wr_addr : w_rd_acc ? bus.rd_addr : {ADDR_WIDTH{1'b0}};
      bus.ram_wdata = w_grant ? bus.hpb_wr_data : {DATA_WIDTH{1'b0}};
      bus.ram_be    = w_grant ? bus.hpb_wr_byte_en : {BE_WIDTH{1'b0}};
      case (r_state)
         W_IDLE:  w_next = bus.hpb_wr_req ? W_PEND : W_IDLE;
         W_PEND:  w_next = w_grant ? W_DONE : W_PEND;
         W_DONE:  w_next = W_REARM;
         default: w_next = bus.hpb_wr_req ? W_REARM : W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= W_IDLE;
         r_starve <= 8'd0;
         r_vld    <= '0;
         r_stall  <= 16'd0;
      end else begin
         r_state  <= w_next;
         r_starve <= (r_state == W_PEND && bus.rd_req && !w_grant) ? r_starve + 8'd1 : 8'd0;
         r_vld    <= RD_LATENCY'({r_vld, w_rd_acc});
         if (bus.rd_req && w_lim && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      end
   end

   // Tags ride alongside the valid pipe; they are masked at the output so need no reset.
   always_ff @(posedge clk) begin
      r_tag[0] <= bus.rd_tag;
      for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
   end

   assign bus.rd_ready      = !w_lim;
   assign bus.rd_valid      = r_vld[RD_LATENCY-1];
   assign bus.rd_data       = bus.rd_valid ? bus.ram_rdata : {DATA_WIDTH{1'b0}};
   assign bus.rd_tag_out    = bus.rd_valid ? r_tag[RD_LATENCY-1] : {TAG_WIDTH{1'b0}};
   assign bus.rcb_wr_done   = r_state == W_DONE;
   assign bus.stat_rd_stall = r_stall;
endmodule

// File: tb/tb_rcb_arb.sv
// tb_rcb_arb: randomized scoreboard bench for rcb_arb with a behavioural RAM
// and a cycle-level reference model of the arbitration rules.
module tb_rcb_arb;
   localparam int AW = 10, DW = 64, BW = 8, TW = 4, LAT = 2, LIM = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rcb_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW)) bus ();
   rcb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW),
             .RD_LATENCY(LAT), .WR_STARVE_LIMIT(LIM)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return (a == 10'h005) ? 64'h00000000DEADBEEF : {22'h0, a, ~{22'h0, a}};
   endfunction

   // Behavioural RAM with LAT-cycle read latency.
   logic [DW-1:0] mem [1024];
   bit            wrt [1024];
   logic [DW-1:0] ram_w, d1, d2;
   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we) begin
         ram_w = wrt[bus.ram_addr] ? mem[bus.ram_addr] : init_word(bus.ram_addr);
         for (int b = 0; b < BW; b++) if (bus.ram_be[b]) ram_w[b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
         mem[bus.ram_addr] <= ram_w;
         wrt[bus.ram_addr] <= 1'b1;
      end
      d1 <= (bus.ram_en && !bus.ram_we) ? (wrt[bus.ram_addr] ? mem[bus.ram_addr] : init_word(bus.ram_addr)) : '0;
      d2 <= d1;
   end
   assign bus.ram_rdata = d2;

   typedef struct {int due; logic [DW-1:0] data; logic [TW-1:0] tag;} rd_exp_t;
   rd_exp_t q_rd [$];
   int      q_done [$];
   int      vectors = 0, miscompares = 0, cyc = 0;
   bit      started = 1'b0;

   // Reference model state
   logic [DW-1:0] ref_mem [1024];
   bit            w_pending, need_low, m_ready;
   int            waited, done_at, ref_stall;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [BW-1:0] wbe;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input bit rq, input logic [AW-1:0] a, input logic [TW-1:0] t, input bit wq, input bit rst_n);
      bit lim, gr, acc, start;
      logic [AW-1:0] e_ad;
      logic [DW-1:0] e_wd;
      logic [BW-1:0] e_be;
      bus.rd_req = rq;
      bus.rd_addr = a;
      bus.rd_tag = t;
      bus.hpb_wr_req = wq;
      bus.hpb_wr_addr = waddr;
      bus.hpb_wr_data = wdata;
      bus.hpb_wr_byte_en = wbe;
      reset_n = rst_n;
      #1;
      lim = w_pending && waited == LIM;
      m_ready = !lim;
      gr = w_pending && (!rq || lim);
      acc = rq && m_ready;
      e_ad = gr ? waddr : acc ? a : '0;
      e_wd = gr ? wdata : '0;
      e_be = gr ? wbe : '0;
      check("ram_port", 128'({bus.rd_ready, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_be, bus.stat_rd_stall}),
            128'({m_ready, acc | gr, gr, e_ad, e_wd, e_be, 16'(ref_stall)}));
      if (acc) q_rd.push_back('{due: cyc + LAT, data: ref_mem[a], tag: t});
      if (gr) begin
         for (int b = 0; b < BW; b++) if (wbe[b]) ref_mem[waddr][b*8 +: 8] = wdata[b*8 +: 8];
         q_done.push_back(cyc + 1);
      end
      if (rq && !m_ready && ref_stall < 65535) ref_stall++;
      start = !w_pending && !need_low && wq;
      if (gr) begin
         w_pending = 1'b0;
         need_low = 1'b1;
         done_at = cyc + 1;
      end else if (w_pending && rq) waited++;
      if (start) begin
         w_pending = 1'b1;
         waited = 0;
      end
      if (need_low && cyc > done_at && !wq) need_low = 1'b0;
      if (!rst_n) begin
         w_pending = 1'b0;
         need_low = 1'b0;
         waited = 0;
         ref_stall = 0;
         while (q_rd.size() > 0 && q_rd[q_rd.size()-1].due > cyc) void'(q_rd.pop_back());
         while (q_done.size() > 0 && q_done[q_done.size()-1] > cyc) void'(q_done.pop_back());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   bit ev_rd, ev_dn;
   always @(negedge clk) if (started) begin
      while (q_rd.size() > 0 && q_rd[0].due < cyc) begin
         check("rd_missing", 128'(q_rd[0].due), 128'(cyc));
         void'(q_rd.pop_front());
      end
      ev_rd = q_rd.size() > 0 && q_rd[0].due == cyc;
      check("rd_valid", 128'(bus.rd_valid), 128'(ev_rd));
      if (ev_rd) begin
         check("rd_data", 128'(bus.rd_data), 128'(q_rd[0].data));
         check("rd_tag", 128'(bus.rd_tag_out), 128'(q_rd[0].tag));
         void'(q_rd.pop_front());
      end else check("rd_idle", 128'({bus.rd_data, bus.rd_tag_out}), 128'(0));
      while (q_done.size() > 0 && q_done[0] < cyc) begin
         check("done_missing", 128'(q_done[0]), 128'(cyc));
         void'(q_done.pop_front());
      end
      ev_dn = q_done.size() > 0 && q_done[0] == cyc;
      check("wr_done", 128'(bus.rcb_wr_done), 128'(ev_dn));
      if (ev_dn) void'(q_done.pop_front());
   end

   initial begin
      bit rq, wq;
      logic [AW-1:0] a;
      logic [TW-1:0] t;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
      waddr = '0;
      wdata = '0;
      wbe = '0;
      bus.rd_req = 1'b0;
      bus.rd_addr = '0;
      bus.rd_tag = '0;
      bus.hpb_wr_req = 1'b0;
      bus.hpb_wr_addr = '0;
      bus.hpb_wr_data = '0;
      bus.hpb_wr_byte_en = '0;
      repeat (3) @(posedge clk);
      #1;
      started = 1'b1;
      check("reset_stat", 128'(bus.stat_rd_stall), 128'(0));
      // Single read of preloaded word
      drive(1, 10'h005, 4'h3, 0, 1);
      repeat (3) drive(0, 0, 0, 0, 1);
      // Idle write, held 3 cycles past done, then readback
      waddr = 10'h010;
      wdata = 64'h1122334455667788;
      wbe = 8'h0F;
      repeat (6) drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 1);
      drive(1, 10'h010, 4'h1, 0, 1);
      repeat (3) drive(0, 0, 0, 0, 1);
      check("readback_mem", 128'(ref_mem[10'h010]), 128'({init_word(10'h010)} & 64'hFFFFFFFF00000000 | 64'h55667788));
      // Write pending under continuous reads: forced after LIM blocked cycles
      waddr = 10'h020;
      wdata = {$urandom, $urandom};
      wbe = 8'hFF;
      a = 10'h040;
      t = 4'h0;
      for (int k = 0; k < 14; k++) begin
         drive(1, a, t, 1, 1);
         if (m_ready) begin
            a++;
            t++;
         end
      end
      check("stall_count", 128'(bus.stat_rd_stall), 128'(1));
      repeat (3) drive(0, 0, 0, 0, 1);
      // 16 back-to-back reads
      for (int i = 0; i < 16; i++) drive(1, 10'h100 + 10'(i), 4'(i), 0, 1);
      repeat (3) drive(0, 0, 0, 0, 1);
      // Reset with reads in flight and a write pending
      waddr = 10'h030;
      for (int k = 0; k < 4; k++) drive(1, 10'h050 + 10'(k), 4'(k), 1, 1);
      drive(1, 10'h060, 4'hA, 1, 0);
      drive(0, 0, 0, 0, 1);
      repeat (3) drive(0, 0, 0, 0, 1);
      // Randomized traffic
      rq = 0;
      wq = 0;
      a = '0;
      t = '0;
      for (int n = 0; n < 800; n++) begin
         if (!(rq && !m_ready)) begin
            rq = $urandom_range(0, 99) < 85;
            a = 10'($urandom_range(0, 31));
            t = 4'($urandom);
         end
         if (wq) begin
            if (need_low && cyc > done_at && $urandom_range(0, 1) == 1) wq = 0;
         end else if (!need_low && !w_pending && $urandom_range(0, 7) == 0) begin
            wq = 1;
            waddr = 10'($urandom_range(0, 31));
            wdata = {$urandom, $urandom};
            wbe = 8'($urandom);
         end
         drive(rq, a, t, wq, 1);
      end
      repeat (12) drive(0, 0, 0, 0, 1);
      check("sb_drained", 128'(q_rd.size() + q_done.size()), 128'(0));
      started = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
